// File: rtl/bit_serializer_pkg.sv
// Shared types and constants for the word-to-bit serializer.
package bit_serializer_pkg;

  localparam int SER_WIDTH = 8;

  // One-hot state encoding
  typedef enum logic [2:0] {
    IDLE   = 3'b001,
    SHIFT  = 3'b010,
    PARITY = 3'b100
  } ser_state_e;

endpackage

// File: rtl/ser_hold_buf.sv
// One-entry word buffer with valid flag; fills on load, empties on take.
module ser_hold_buf
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             take,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full
);

  // load and take never coincide: a word is only accepted while the buffer is empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= '0;
      full <= 1'b0;
    end else if (load) begin
      dout <= din;
      full <= 1'b1;
    end else if (take) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/bit_serializer.sv
// MSB-first word serializer with a one-entry hold buffer for gapless back-to-back frames.
// Optional even-parity trailer bit when SER_PARITY_EN is defined.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int   WIDTH      = SER_WIDTH,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             data_out,
  output logic             bit_valid,
  output logic             frame_last,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);

  ser_state_e       state, state_d;
  logic [CNT_W-1:0] bit_cnt, cnt_d;
  logic [WIDTH-2:0] rest, rest_d;
  logic             dout_d, bv_d, fl_d, busy_d;
  logic             accept, start, frame_end;
  logic [WIDTH-1:0] start_word;
  logic             hold_load, hold_take, hold_full;
  logic [WIDTH-1:0] hold_dout;
`ifdef SER_PARITY_EN
  logic             par, par_d;
`endif

  assign s_ready = ~hold_full;
  assign accept  = s_valid & s_ready;

  ser_hold_buf #(.WIDTH(WIDTH)) u_hold (
    .clk  (clk),
    .rst  (rst),
    .load (hold_load),
    .take (hold_take),
    .din  (s_data),
    .dout (hold_dout),
    .full (hold_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      rest       <= '0;
      data_out   <= IDLE_LEVEL;
      bit_valid  <= 1'b0;
      frame_last <= 1'b0;
      busy       <= 1'b0;
`ifdef SER_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      state      <= state_d;
      bit_cnt    <= cnt_d;
      rest       <= rest_d;
      data_out   <= dout_d;
      bit_valid  <= bv_d;
      frame_last <= fl_d;
      busy       <= busy_d;
`ifdef SER_PARITY_EN
      par        <= par_d;
`endif
    end
  end

  always_comb begin
    state_d    = state;
    cnt_d      = bit_cnt;
    rest_d     = rest;
    dout_d     = IDLE_LEVEL;
    bv_d       = 1'b0;
    fl_d       = 1'b0;
    hold_load  = 1'b0;
    hold_take  = 1'b0;
    start      = 1'b0;
    start_word = s_data;
    frame_end  = 1'b0;
`ifdef SER_PARITY_EN
    par_d      = par;
`endif

    case (state)
      IDLE: start = accept;
      SHIFT: begin
        if (bit_cnt != '0) begin
          cnt_d     = bit_cnt - 1'b1;
          rest_d    = rest << 1;
          dout_d    = rest[WIDTH-2];
          bv_d      = 1'b1;
`ifdef SER_PARITY_EN
          fl_d      = 1'b0;
`else
          fl_d      = (bit_cnt == CNT_W'(1));
`endif
          hold_load = accept;
        end else begin
`ifdef SER_PARITY_EN
          state_d   = PARITY;
          dout_d    = par;
          bv_d      = 1'b1;
          fl_d      = 1'b1;
          hold_load = accept;
`else
          frame_end = 1'b1;
`endif
        end
      end
      PARITY:  frame_end = 1'b1;
      default: state_d = IDLE;
    endcase

    // On the final frame cycle the held word has priority over a fresh input
    if (frame_end) begin
      if (hold_full) begin
        start      = 1'b1;
        start_word = hold_dout;
        hold_take  = 1'b1;
      end else if (accept) begin
        start = 1'b1;
      end else begin
        state_d = IDLE;
      end
    end

    if (start) begin
      state_d = SHIFT;
      cnt_d   = CNT_W'(WIDTH - 1);
      rest_d  = start_word[WIDTH-2:0];
      dout_d  = start_word[WIDTH-1];
      bv_d    = 1'b1;
      fl_d    = 1'b0;
`ifdef SER_PARITY_EN
      par_d   = ^start_word;
`endif
    end

    busy_d = (state_d != IDLE) | hold_load | (hold_full & ~hold_take);
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer; build with or without SER_PARITY_EN.
module tb_bit_serializer;

`ifdef SER_PARITY_EN
  localparam int FL  = 9;
  localparam bit PAR = 1'b1;
`else
  localparam int FL  = 8;
  localparam bit PAR = 1'b0;
`endif

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  logic       clk, rst, s_valid, s_ready, data_out, bit_valid, frame_last, busy;
  logic [7:0] s_data;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   run = 0;
  int   last_run = 0;
  int   valid_seen = 0;
  int   det_cnt = 0;
  int   det_fill = 0;
  logic [2:0] hist = 3'b000;

  bit_serializer #(.WIDTH(8), .IDLE_LEVEL(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .data_out   (data_out),
    .bit_valid  (bit_valid),
    .frame_last (frame_last),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expected bit per valid cycle, also feeds a 101 detector
  always @(negedge clk) begin
    if (!rst) begin
      if (bit_valid) begin
        exp_t e;
        run++;
        valid_seen++;
        hist = {hist[1:0], data_out};
        det_fill++;
        if (det_fill >= 3 && hist == 3'b101) det_cnt++;
        if (sb.size() == 0) begin
          chk("spurious_bit_valid", {31'b0, bit_valid}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("data_out", {31'b0, data_out}, {31'b0, e.b});
          chk("frame_last", {31'b0, frame_last}, {31'b0, e.last});
        end
      end else begin
        if (run != 0) last_run = run;
        run = 0;
        det_fill = 0;
        chk("idle_data_out", {31'b0, data_out}, 32'd0);
        chk("idle_frame_last", {31'b0, frame_last}, 32'd0);
      end
    end
  end

  task automatic push_word(input logic [7:0] w, input logic p);
    exp_t e;
    for (int i = 7; i >= 0; i--) begin
      e.b    = w[i];
      e.last = (i == 0) && !PAR;
      sb.push_back(e);
    end
    if (PAR) begin
      e.b    = p;
      e.last = 1'b1;
      sb.push_back(e);
    end
  endtask

  // Presents a word, waits for s_ready, returns #1 after the accepting edge
  task automatic send(input logic [7:0] w, input logic p);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = w;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      chk("s_ready_timeout", {31'b0, s_ready}, 32'd1);
    end else begin
      push_word(w, p);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!(sb.size() == 0 && !bit_valid && !busy) && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= 200) chk(name, {31'b0, busy}, 32'd0);
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    #2 rst  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_out", {31'b0, data_out}, 32'd0);
    chk("rst_bit_valid", {31'b0, bit_valid}, 32'd0);
    chk("rst_frame_last", {31'b0, frame_last}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_s_ready", {31'b0, s_ready}, 32'd1);
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Single word: 0xA5 -> 1,0,1,0,0,1,0,1
    send(8'hA5, 1'b0);
    chk("a5_busy", {31'b0, busy}, 32'd1);
    wait_idle("a5_drain");
    chk("a5_run", last_run, FL);

    // Streaming with hold buffer
    send(8'hFF, 1'b0);
    send(8'h00, 1'b0);
    chk("hold_full_s_ready", {31'b0, s_ready}, 32'd0);
    chk("hold_full_busy", {31'b0, busy}, 32'd1);
    send(8'h5A, 1'b0);
    wait_idle("stream_drain");
    chk("stream_run", last_run, 3 * FL);
    chk("stream_s_ready", {31'b0, s_ready}, 32'd1);

    // New word arrives exactly on the last-bit cycle with hold empty
    send(8'h3C, 1'b0);
    repeat (FL - 1) @(posedge clk);
    #1;
    chk("lastbit_hold_empty", {31'b0, s_ready}, 32'd1);
    send(8'h81, 1'b0);
    wait_idle("lastbit_drain");
    chk("lastbit_run", last_run, 2 * FL);

    // Reset during bit 3 of 0xC3 with a word held
    send(8'hC3, 1'b0);
    send(8'h24, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_data_out", {31'b0, data_out}, 32'd0);
    chk("arst_bit_valid", {31'b0, bit_valid}, 32'd0);
    chk("arst_frame_last", {31'b0, frame_last}, 32'd0);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_s_ready", {31'b0, s_ready}, 32'd1);
    sb.delete();
    @(negedge clk);
    #1 rst = 1'b0;
    valid_seen = 0;
    repeat (12) @(posedge clk);
    #2;
    chk("post_rst_valid", valid_seen, 0);
    chk("post_rst_busy", {31'b0, busy}, 32'd0);

    // Parity words: 0x07 -> parity 1, 0x03 -> parity 0
    send(8'h07, 1'b1);
    wait_idle("p07_drain");
    chk("p07_run", last_run, FL);
    send(8'h03, 1'b0);
    wait_idle("p03_drain");

    // 0x05 contains 101 once
    det_cnt = 0;
    send(8'h05, 1'b0);
    wait_idle("det_drain");
    chk("det_101", det_cnt, 1);

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
